mc_control_fsm: RTL and testbench
=================================

// Module: mc_control_fsm
// PURPOSE
//  Multicycle control unit for the 16-bit TSC datapath; the producing end of the ALU's func_code/branch_type interface.
//  Sequences each instruction through IF/ID/EX/MEM/WB, waits on the memory handshake, and drives all datapath enables.
//  Consumes the ALU's bcond. Sits between the IR and the datapath muxes/registers in cpu top.
// PARAMETERS
//  WORD_W           16  datapath/instruction width
//  HALT_ON_UNKNOWN  1   1: an undefined opcode/func enters S_HALT; 0: it retires as a NOP (ID->IF)
// PORTS
//  clk            in   1  clock, rising edge
//  reset_n        in   1  asynchronous active-low reset
//  instr          in   16 IR contents; valid from S_ID onward
//  mem_ready      in   1  memory ack; completes the current mem_read/mem_write this cycle
//  bcond          in   1  ALU branch condition (combinational from ALU C)
//  mem_read       out  1  memory read request (held until mem_ready)
//  mem_write      out  1  memory write request (held until mem_ready)
//  i_or_d         out  1  0: address=PC, 1: address=ALUOut
//  ir_write       out  1  load IR (1-cycle pulse)
//  pc_write       out  1  unconditional PC load
//  pc_write_cond  out  1  PC load qualified by bcond (gated internally; pc_write reflects it)
//  pc_source      out  2  0: ALU C, 1: ALUOut, 2: {PC[15:12],instr[11:0]}, 3: reg A
//  alu_src_a      out  1  0: PC, 1: reg A
//  alu_src_b      out  2  0: reg B, 1: const 1, 2: sext imm8, 3: zext imm8
//  func_code      out  4  ALU op, `FUNC_* encodings of opcodes.v
//  branch_type    out  2  `BRANCH_* of opcodes.v
//  reg_write      out  1  register file write enable
//  reg_dst        out  2  0: rt, 1: rd, 2: r2 (link)
//  mem_to_reg     out  2  0: ALUOut, 1: MDR, 2: PC
//  wwd            out  1  output-port latch of reg A (1-cycle pulse)
//  inst_done      out  1  pulse in the final cycle of each retired instruction
//  halted         out  1  high while in S_HALT
// BEHAVIOUR
//  - Reset (async, any state, mid-handshake included): state=S_IF; every output 0 immediately; mem_read asserts in the first cycle after release.
//  - Outputs decoded from state + instr; no output is registered separately.
//  - S_IF: mem_read=1, i_or_d=0. Stay while !mem_ready. On mem_ready: ir_write=1, pc_write=1, pc_source=0, alu PC+1 (src_a=0, src_b=1, ADD); -> S_ID.
//  - S_ID: ALUOut <= PC+sext imm (ADD, src_a=0, src_b=2). JMP: pc_write, pc_source=2, done. JAL: same + reg_write, reg_dst=2, mem_to_reg=2. HLT -> S_HALT. Else -> S_EX.
//  - S_EX: R-ALU: src_a=1, src_b=0, func per instr func -> S_WB. ADI/LWD/SWD: ADD, src_b=2. ORI: ORR, src_b=3. LHI: `FUNC_LHI, src_b=3. -> S_WB or S_MEM.
//    Branch: BNE/BEQ use SUB (src_a=1, src_b=0); BGZ/BLZ use IDN. branch_type from opcode; pc_write_cond=1, pc_source=1; done.
//    JPR: pc_write, pc_source=3, done. JRL: same + reg_write, reg_dst=2, mem_to_reg=2 (old PC+1). WWD: wwd=1, done.
//  - S_MEM: i_or_d=1; LWD mem_read / SWD mem_write, held until mem_ready. LWD -> S_WB; SWD done.
//  - S_WB: reg_write=1; R-type reg_dst=1, else 0; mem_to_reg=1 for LWD else 0; done.
//  - "done" = inst_done=1 and next state S_IF. The PC load and reg write commit on the same edge.
//  - Minimum cycles with zero-wait memory: JMP/JAL 2; branch/JPR/JRL/WWD 3; R/imm 4; SWD 4; LWD 5.
//    Each memory wait cycle adds 1.
//  - mem_read and mem_write never high together; mem_ready outside S_IF/S_MEM is ignored.
//  - S_HALT: absorbing; halted=1; all other outputs 0; leaves only on reset.
//  - overflow_flag is not consumed; ADD/SUB with overflow still writes back.
// TESTING
//  - Reset: hold reset_n=0 for 3 cycles, release -> cycle 1 has mem_read=1, i_or_d=0; all other outputs 0. Drop reset_n in S_MEM -> outputs 0 in the same cycle.
//  - ADD r1,r2->r3 (0xF6C0), mem_ready=1 immediately -> IF,ID,EX(func ADD, src_a=1, src_b=0),WB(reg_write, reg_dst=1); inst_done in cycle 4.
//  - LWD (0x7105) with 2 wait cycles in S_IF and 1 in S_MEM -> 8 cycles total; mem_to_reg=1 in WB.
//  - BEQ (0x1102): bcond=1 -> pc_write=1, pc_source=1 in EX; bcond=0 -> pc_write=0. Both retire in 3 cycles.
//  - JAL (0xA123) -> done in S_ID: pc_source=2, reg_dst=2, mem_to_reg=2. HLT (0xF01D) -> halted=1 held 20 cycles, mem_read stays 0.
//  - Opcode 0xB with HALT_ON_UNKNOWN=1 -> S_HALT; with 0 -> inst_done in S_ID, next S_IF.

Source files
------------

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multicycle IF/ID/EX/MEM/WB control unit for the 16-bit TSC datapath
module mc_control_fsm #(
  parameter int WORD_W          = 16,
  parameter bit HALT_ON_UNKNOWN = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [WORD_W-1:0] instr,
  input  logic              mem_ready,
  input  logic              bcond,
  output logic              mem_read,
  output logic              mem_write,
  output logic              i_or_d,
  output logic              ir_write,
  output logic              pc_write,
  output logic              pc_write_cond,
  output logic [1:0]        pc_source,
  output logic              alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic [3:0]        func_code,
  output logic [1:0]        branch_type,
  output logic              reg_write,
  output logic [1:0]        reg_dst,
  output logic [1:0]        mem_to_reg,
  output logic              wwd,
  output logic              inst_done,
  output logic              halted
);

  localparam logic [3:0] FUNC_ADD = 4'd0;
  localparam logic [3:0] FUNC_SUB = 4'd1;
  localparam logic [3:0] FUNC_ORR = 4'd3;
  localparam logic [3:0] FUNC_LHI = 4'd8;
  localparam logic [3:0] FUNC_IDN = 4'd9;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  state_t state, next_state;

  logic [3:0] op;
  logic [5:0] func;
  logic       is_r, is_r_alu, is_jpr, is_jrl, is_wwd, is_hlt;
  logic       is_branch, is_adi, is_ori, is_lhi, is_lwd, is_swd, is_jmp, is_jal;
  logic       is_known;
  logic       unused_bits;

  assign op          = instr[WORD_W-1 -: 4];
  assign func        = instr[5:0];
  assign unused_bits = ^instr;

  assign is_r      = (op == 4'hF);
  assign is_r_alu  = is_r && (func[5:3] == 3'b000);
  assign is_jpr    = is_r && (func == 6'd25);
  assign is_jrl    = is_r && (func == 6'd26);
  assign is_wwd    = is_r && (func == 6'd28);
  assign is_hlt    = is_r && (func == 6'd29);
  assign is_branch = (op[3:2] == 2'b00);
  assign is_adi    = (op == 4'h4);
  assign is_ori    = (op == 4'h5);
  assign is_lhi    = (op == 4'h6);
  assign is_lwd    = (op == 4'h7);
  assign is_swd    = (op == 4'h8);
  assign is_jmp    = (op == 4'h9);
  assign is_jal    = (op == 4'hA);
  assign is_known  = is_r_alu | is_jpr | is_jrl | is_wwd | is_hlt | is_branch |
                     is_adi | is_ori | is_lhi | is_lwd | is_swd | is_jmp | is_jal;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IF;
    else          state <= next_state;
  end

  // Outputs are gated by reset_n so they drop in the same cycle reset asserts.
  always_comb begin
    next_state    = state;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'd0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    func_code     = FUNC_ADD;
    branch_type   = 2'd0;
    reg_write     = 1'b0;
    reg_dst       = 2'd0;
    mem_to_reg    = 2'd0;
    wwd           = 1'b0;
    inst_done     = 1'b0;
    halted        = 1'b0;
    if (reset_n) begin
      case (state)
        S_IF: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            alu_src_b  = 2'd1;
            next_state = S_ID;
          end
        end
        S_ID: begin
          alu_src_b = 2'd2;
          if (is_jmp || is_jal) begin
            pc_write   = 1'b1;
            pc_source  = 2'd2;
            inst_done  = 1'b1;
            next_state = S_IF;
            if (is_jal) begin
              reg_write  = 1'b1;
              reg_dst    = 2'd2;
              mem_to_reg = 2'd2;
            end
          end else if (is_hlt) begin
            next_state = S_HALT;
          end else if (!is_known) begin
            if (HALT_ON_UNKNOWN) begin
              next_state = S_HALT;
            end else begin
              inst_done  = 1'b1;
              next_state = S_IF;
            end
          end else begin
            next_state = S_EX;
          end
        end
        S_EX: begin
          if (is_r_alu) begin
            alu_src_a  = 1'b1;
            func_code  = func[3:0];
            next_state = S_WB;
          end else if (is_branch) begin
            alu_src_a     = 1'b1;
            func_code     = op[1] ? FUNC_IDN : FUNC_SUB;
            branch_type   = op[1:0];
            pc_write_cond = 1'b1;
            pc_write      = bcond;
            pc_source     = 2'd1;
            inst_done     = 1'b1;
            next_state    = S_IF;
          end else if (is_jpr || is_jrl) begin
            pc_write   = 1'b1;
            pc_source  = 2'd3;
            inst_done  = 1'b1;
            next_state = S_IF;
            if (is_jrl) begin
              reg_write  = 1'b1;
              reg_dst    = 2'd2;
              mem_to_reg = 2'd2;
            end
          end else if (is_wwd) begin
            wwd        = 1'b1;
            inst_done  = 1'b1;
            next_state = S_IF;
          end else begin
            alu_src_a  = 1'b1;
            alu_src_b  = (is_ori || is_lhi) ? 2'd3 : 2'd2;
            func_code  = is_ori ? FUNC_ORR : (is_lhi ? FUNC_LHI : FUNC_ADD);
            next_state = (is_lwd || is_swd) ? S_MEM : S_WB;
          end
        end
        S_MEM: begin
          i_or_d    = 1'b1;
          mem_read  = is_lwd;
          mem_write = is_swd;
          if (mem_ready) begin
            if (is_lwd) begin
              next_state = S_WB;
            end else begin
              inst_done  = 1'b1;
              next_state = S_IF;
            end
          end
        end
        S_WB: begin
          reg_write  = 1'b1;
          reg_dst    = is_r_alu ? 2'd1 : 2'd0;
          mem_to_reg = is_lwd ? 2'd1 : 2'd0;
          inst_done  = 1'b1;
          next_state = S_IF;
        end
        S_HALT: halted = 1'b1;
        default: next_state = S_IF;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - scoreboard bench for mc_control_fsm (HALT_ON_UNKNOWN 1 and 0)
module tb_mc_control_fsm;

  localparam logic [3:0] F_ADD = 4'd0;
  localparam logic [3:0] F_SUB = 4'd1;
  localparam logic [3:0] F_ORR = 4'd3;
  localparam logic [3:0] F_LHI = 4'd8;
  localparam logic [3:0] F_IDN = 4'd9;

  typedef struct packed {
    logic       mr, mw, iod, irw, pcw, pcwc;
    logic [1:0] pcs;
    logic       sa;
    logic [1:0] sb;
    logic [3:0] fc;
    logic [1:0] bt;
    logic       rw;
    logic [1:0] rd, m2r;
    logic       wwd, done, halt;
  } outs_t;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        bc;
    logic [15:0] ins;
    outs_t       e0;
    outs_t       e1;
  } step_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] instr;
  logic        mem_ready, bcond;

  logic       o0_mem_read, o0_mem_write, o0_i_or_d, o0_ir_write, o0_pc_write, o0_pc_write_cond;
  logic [1:0] o0_pc_source, o0_alu_src_b, o0_branch_type, o0_reg_dst, o0_mem_to_reg;
  logic       o0_alu_src_a, o0_reg_write, o0_wwd, o0_inst_done, o0_halted;
  logic [3:0] o0_func_code;
  logic       o1_mem_read, o1_mem_write, o1_i_or_d, o1_ir_write, o1_pc_write, o1_pc_write_cond;
  logic [1:0] o1_pc_source, o1_alu_src_b, o1_branch_type, o1_reg_dst, o1_mem_to_reg;
  logic       o1_alu_src_a, o1_reg_write, o1_wwd, o1_inst_done, o1_halted;
  logic [3:0] o1_func_code;

  outs_t act0, act1;
  step_t plan[$];
  step_t sb_q[$];
  step_t mon_s;
  int    n_checks = 0;
  int    n_pass   = 0;

  always #5 clk = ~clk;

  mc_control_fsm #(.WORD_W(16), .HALT_ON_UNKNOWN(1'b1)) dut0 (
    .clk(clk), .reset_n(reset_n), .instr(instr), .mem_ready(mem_ready), .bcond(bcond),
    .mem_read(o0_mem_read), .mem_write(o0_mem_write), .i_or_d(o0_i_or_d),
    .ir_write(o0_ir_write), .pc_write(o0_pc_write), .pc_write_cond(o0_pc_write_cond),
    .pc_source(o0_pc_source), .alu_src_a(o0_alu_src_a), .alu_src_b(o0_alu_src_b),
    .func_code(o0_func_code), .branch_type(o0_branch_type), .reg_write(o0_reg_write),
    .reg_dst(o0_reg_dst), .mem_to_reg(o0_mem_to_reg), .wwd(o0_wwd),
    .inst_done(o0_inst_done), .halted(o0_halted)
  );

  mc_control_fsm #(.WORD_W(16), .HALT_ON_UNKNOWN(1'b0)) dut1 (
    .clk(clk), .reset_n(reset_n), .instr(instr), .mem_ready(mem_ready), .bcond(bcond),
    .mem_read(o1_mem_read), .mem_write(o1_mem_write), .i_or_d(o1_i_or_d),
    .ir_write(o1_ir_write), .pc_write(o1_pc_write), .pc_write_cond(o1_pc_write_cond),
    .pc_source(o1_pc_source), .alu_src_a(o1_alu_src_a), .alu_src_b(o1_alu_src_b),
    .func_code(o1_func_code), .branch_type(o1_branch_type), .reg_write(o1_reg_write),
    .reg_dst(o1_reg_dst), .mem_to_reg(o1_mem_to_reg), .wwd(o1_wwd),
    .inst_done(o1_inst_done), .halted(o1_halted)
  );

  assign act0 = {o0_mem_read, o0_mem_write, o0_i_or_d, o0_ir_write, o0_pc_write,
                 o0_pc_write_cond, o0_pc_source, o0_alu_src_a, o0_alu_src_b, o0_func_code,
                 o0_branch_type, o0_reg_write, o0_reg_dst, o0_mem_to_reg, o0_wwd,
                 o0_inst_done, o0_halted};
  assign act1 = {o1_mem_read, o1_mem_write, o1_i_or_d, o1_ir_write, o1_pc_write,
                 o1_pc_write_cond, o1_pc_source, o1_alu_src_a, o1_alu_src_b, o1_func_code,
                 o1_branch_type, o1_reg_write, o1_reg_dst, o1_mem_to_reg, o1_wwd,
                 o1_inst_done, o1_halted};

  task automatic check(input string name, input logic [15:0] ins, input outs_t got, input outs_t exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s ins=%h got=%h exp=%h", name, ins, got, exp);
  endtask

  task automatic add2(input logic rst, input logic [15:0] ins, input logic bc, input logic rdy,
                      input outs_t e0, input outs_t e1);
    step_t s;
    s.rst = rst; s.rdy = rdy; s.bc = bc; s.ins = ins; s.e0 = e0; s.e1 = e1;
    plan.push_back(s);
  endtask

  task automatic add(input logic [15:0] ins, input logic bc, input logic rdy, input outs_t e);
    add2(1'b1, ins, bc, rdy, e, e);
  endtask

  task automatic add_reset(input int n);
    for (int i = 0; i < n; i++) add2(1'b0, 16'h0, 1'b0, 1'($urandom_range(0, 1)), '0, '0);
  endtask

  // Expected per-cycle outputs for one instruction, derived from its class and wait counts.
  task automatic build(input logic [15:0] ins, input int wif, input int wmem, input logic bc);
    logic [3:0] op;
    logic [5:0] fn;
    outs_t      e;
    op = ins[15:12];
    fn = ins[5:0];
    for (int i = 0; i < wif; i++) begin
      e = '0; e.mr = 1; add(ins, bc, 1'b0, e);
    end
    e = '0; e.mr = 1; e.irw = 1; e.pcw = 1; e.sb = 2'd1; e.fc = F_ADD;
    add(ins, bc, 1'b1, e);
    e = '0; e.sb = 2'd2; e.fc = F_ADD;
    if (op == 4'h9 || op == 4'hA) begin
      e.pcw = 1; e.pcs = 2'd2; e.done = 1;
      if (op == 4'hA) begin e.rw = 1; e.rd = 2'd2; e.m2r = 2'd2; end
      add(ins, bc, 1'($urandom_range(0, 1)), e);
      return;
    end
    add(ins, bc, 1'($urandom_range(0, 1)), e);
    if (op == 4'hF && fn == 6'd29) return;
    e = '0;
    if (op <= 4'h3) begin
      e.sa = 1; e.fc = (op < 4'h2) ? F_SUB : F_IDN; e.bt = op[1:0];
      e.pcwc = 1; e.pcw = bc; e.pcs = 2'd1; e.done = 1;
      add(ins, bc, 1'($urandom_range(0, 1)), e);
      return;
    end
    if (op == 4'hF) begin
      if (fn <= 6'd7) begin
        e.sa = 1; e.fc = fn[3:0];
        add(ins, bc, 1'($urandom_range(0, 1)), e);
        e = '0; e.rw = 1; e.rd = 2'd1; e.done = 1;
      end else if (fn == 6'd25 || fn == 6'd26) begin
        e.pcw = 1; e.pcs = 2'd3; e.done = 1;
        if (fn == 6'd26) begin e.rw = 1; e.rd = 2'd2; e.m2r = 2'd2; end
      end else begin
        e.wwd = 1; e.done = 1;
      end
      add(ins, bc, 1'($urandom_range(0, 1)), e);
      return;
    end
    e.sa = 1;
    e.sb = (op == 4'h5 || op == 4'h6) ? 2'd3 : 2'd2;
    e.fc = (op == 4'h5) ? F_ORR : ((op == 4'h6) ? F_LHI : F_ADD);
    add(ins, bc, 1'($urandom_range(0, 1)), e);
    if (op == 4'h7 || op == 4'h8) begin
      for (int i = 0; i <= wmem; i++) begin
        e = '0; e.iod = 1; e.mr = (op == 4'h7); e.mw = (op == 4'h8);
        e.done = (op == 4'h8) && (i == wmem);
        add(ins, bc, (i == wmem), e);
      end
      if (op == 4'h8) return;
    end
    e = '0; e.rw = 1; e.m2r = (op == 4'h7) ? 2'd1 : 2'd0; e.done = 1;
    add(ins, bc, 1'($urandom_range(0, 1)), e);
  endtask

  // Undefined encoding: the halting variant parks in S_HALT, the other retires from ID.
  task automatic build_unknown(input logic [15:0] ins);
    outs_t e0, e1;
    e0 = '0; e0.mr = 1; e0.irw = 1; e0.pcw = 1; e0.sb = 2'd1;
    add(ins, 1'b0, 1'b1, e0);
    e0 = '0; e0.sb = 2'd2; e1 = e0; e1.done = 1;
    add2(1'b1, ins, 1'b0, 1'b0, e0, e1);
    for (int i = 0; i < 20; i++) begin
      e0 = '0; e0.halt = 1; e1 = '0; e1.mr = 1;
      add2(1'b1, ins, 1'b0, 1'b0, e0, e1);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        mon_s = sb_q.pop_front();
        check("dut0_outputs", mon_s.ins, act0, mon_s.e0);
        check("dut1_outputs", mon_s.ins, act1, mon_s.e1);
      end
    end
  end

  initial begin
    int base;
    int ops[12] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 15};
    int fns[11] = '{0, 1, 2, 3, 4, 5, 6, 7, 25, 26, 28};
    logic [15:0] ins;
    outs_t e;
    step_t s;
    reset_n = 1'b0; instr = 16'h0; mem_ready = 1'b0; bcond = 1'b0;

    add_reset(3);
    build(16'hF6C0, 0, 0, 1'b0);
    build(16'h7105, 2, 1, 1'b0);
    build(16'h1102, 0, 0, 1'b1);
    build(16'h1102, 0, 0, 1'b0);
    build(16'hA123, 0, 0, 1'b0);
    base = plan.size();
    build(16'h7105, 0, 2, 1'b0);
    while (plan.size() > base + 4) void'(plan.pop_back());
    add_reset(2);
    for (int n = 0; n < 200; n++) begin
      ins = 16'($urandom);
      ins[15:12] = 4'(ops[$urandom_range(0, 11)]);
      if (ins[15:12] == 4'hF) ins[5:0] = 6'(fns[$urandom_range(0, 10)]);
      build(ins, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end
    add_reset(2);
    build_unknown(16'hB123);
    add_reset(2);
    build_unknown(16'hF00F);
    add_reset(2);
    build(16'hF01D, 0, 0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      e = '0; e.halt = 1;
      add(16'hF01D, 1'b0, 1'($urandom_range(0, 1)), e);
    end

    while (plan.size() > 0) begin
      s = plan.pop_front();
      @(posedge clk);
      #1;
      reset_n   = s.rst;
      mem_ready = s.rdy;
      bcond     = s.bc;
      instr     = s.ins;
      sb_q.push_back(s);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (sb_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain left=%0d required=0", sb_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
